// File: rtl/interval_sequencer_pkg.sv
// Shared types and phase-sequencing helper for the interval sequencer.
// next_phase() folds zero-length or disabled phases into the transition itself.
package interval_pkg;

  localparam int PH_W = 3;

  // Indices into the per-phase duration arrays
  localparam int D_WARM  = 0;
  localparam int D_WORK  = 1;
  localparam int D_REST  = 2;
  localparam int D_COOL  = 3;
  localparam int NUM_DUR = 4;

  typedef enum logic [PH_W-1:0] {
    IDLE     = 3'd0,
    WARMUP   = 3'd1,
    WORK     = 3'd2,
    REST     = 3'd3,
    COOLDOWN = 3'd4,
    FINISH   = 3'd5
  } phase_t;

  // Non-zero flags for the skippable phase durations
  typedef struct packed {
    logic warm;
    logic rest;
    logic cool;
  } phase_len_t;

  typedef struct packed {
    logic warm;
    logic cool;
  } phase_en_t;

  function automatic phase_t next_phase(phase_t cur, logic more_rounds,
                                        phase_len_t nz, phase_en_t en);
    phase_t nxt;
    nxt = IDLE;
    case (cur)
      IDLE:         nxt = (en.warm && nz.warm) ? WARMUP : WORK;
      WARMUP, REST: nxt = WORK;
      WORK: begin
        if (more_rounds) nxt = nz.rest ? REST : WORK;
        else             nxt = (en.cool && nz.cool) ? COOLDOWN : FINISH;
      end
      COOLDOWN:     nxt = FINISH;
      default:      nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/interval_sequencer_if.sv
// Control/config/status bundle between a session controller and the sequencer.
interface interval_sequencer_if #(
  parameter int TIME_W = 8,
  parameter int CNT_W  = 8
);
  import interval_pkg::*;

  logic              tick;
  logic              start;
  logic              skip;
  logic              pause;
  logic              abort;
  logic [CNT_W-1:0]  cfg_rounds;
  logic [TIME_W-1:0] cfg_work_s;
  logic [TIME_W-1:0] cfg_rest_s;
  logic [TIME_W-1:0] cfg_warm_s;
  logic [TIME_W-1:0] cfg_cool_s;
  logic [PH_W-1:0]   state_out;
  logic [TIME_W-1:0] time_left;
  logic [CNT_W-1:0]  rounds_left;
  logic              paused;
  logic              busy;
  logic              beep_phase_end;
  logic              beep_finish;
  logic              done;

  modport master (
    output tick, start, skip, pause, abort,
    output cfg_rounds, cfg_work_s, cfg_rest_s, cfg_warm_s, cfg_cool_s,
    input  state_out, time_left, rounds_left, paused, busy,
    input  beep_phase_end, beep_finish, done
  );

  modport slave (
    input  tick, start, skip, pause, abort,
    input  cfg_rounds, cfg_work_s, cfg_rest_s, cfg_warm_s, cfg_cool_s,
    output state_out, time_left, rounds_left, paused, busy,
    output beep_phase_end, beep_finish, done
  );

endinterface

// File: rtl/interval_sequencer_phase_timer.sv
// Loadable per-phase seconds down-counter; expire flags the tick that ends the phase.
module phase_timer #(
  parameter int TIME_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              hold,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic [TIME_W-1:0] time_left,
  output logic              expire
);

  localparam logic [TIME_W-1:0] ONE = TIME_W'(1);

  logic [TIME_W-1:0] count_reg, count_next;

  // The count never drops below 1 by itself; the owner reloads it at phase end
  always_comb begin
    count_next = count_reg;
    if (load)
      count_next = load_val;
    else if (tick && !hold && (count_reg > ONE))
      count_next = count_reg - ONE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_reg <= '0;
    else        count_reg <= count_next;
  end

  assign expire    = tick && !hold && (count_reg == ONE);
  assign time_left = count_reg;

endmodule

// File: rtl/interval_sequencer.sv
// Workout phase sequencer: IDLE -> WARMUP -> (WORK -> REST) x N -> COOLDOWN -> FINISH,
// with pause/resume, skip, abort and registered beep pulses.
module interval_sequencer
  import interval_pkg::*;
#(
  parameter int TIME_W      = 8,
  parameter int CNT_W       = 8,
  parameter int WARMUP_EN   = 1,
  parameter int COOLDOWN_EN = 1
) (
  input logic                clk,
  input logic                reset,
  interval_sequencer_if.slave bus
);

  phase_t            state_reg, state_next, nxt_phase;
  logic [CNT_W-1:0]  rounds_reg, rounds_next;
  logic              paused_reg, paused_next;
  logic              beep_pe_reg, beep_pe_next;
  logic              beep_fin_reg, beep_fin_next;
  logic [TIME_W-1:0] cfg_in  [NUM_DUR];
  logic [TIME_W-1:0] cfg_reg [NUM_DUR];
  logic [TIME_W-1:0] dur_sel [NUM_DUR];
  logic [TIME_W-1:0] entry_time, tmr_load_val, tmr_time;
  logic              in_idle, active, cfg_latch, more_rounds, phase_end;
  logic              tmr_load, tmr_expire;
  phase_len_t        len_nz;
  phase_en_t         ph_en;

  assign in_idle   = (state_reg == IDLE);
  assign active    = (state_reg inside {WARMUP, WORK, REST, COOLDOWN});
  assign cfg_latch = in_idle && bus.start && !bus.abort && (bus.cfg_rounds != '0);

  assign cfg_in[D_WARM] = bus.cfg_warm_s;
  assign cfg_in[D_WORK] = bus.cfg_work_s;
  assign cfg_in[D_REST] = bus.cfg_rest_s;
  assign cfg_in[D_COOL] = bus.cfg_cool_s;

  // While idle the live config decides the first phase; afterwards only the latched copy counts
  generate
    for (genvar gi = 0; gi < NUM_DUR; gi++) begin : g_cfg
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)         cfg_reg[gi] <= '0;
        else if (cfg_latch) cfg_reg[gi] <= cfg_in[gi];
      end
      assign dur_sel[gi] = in_idle ? cfg_in[gi] : cfg_reg[gi];
    end
  endgenerate

  assign len_nz      = {dur_sel[D_WARM] != '0, dur_sel[D_REST] != '0, dur_sel[D_COOL] != '0};
  assign ph_en       = {WARMUP_EN != 0, COOLDOWN_EN != 0};
  assign more_rounds = (rounds_reg > CNT_W'(1));
  assign nxt_phase   = next_phase(state_reg, more_rounds, len_nz, ph_en);
  assign phase_end   = active && !paused_reg && (tmr_expire || bus.skip);

  always_comb begin
    entry_time = '0;
    case (nxt_phase)
      WARMUP:   entry_time = dur_sel[D_WARM];
      WORK:     entry_time = (dur_sel[D_WORK] == '0) ? TIME_W'(1) : dur_sel[D_WORK];
      REST:     entry_time = dur_sel[D_REST];
      COOLDOWN: entry_time = dur_sel[D_COOL];
      default:  entry_time = '0;
    endcase
  end

  phase_timer #(.TIME_W(TIME_W)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .tick      (bus.tick),
    .hold      (paused_reg || !active),
    .load      (tmr_load),
    .load_val  (tmr_load_val),
    .time_left (tmr_time),
    .expire    (tmr_expire)
  );

  always_comb begin
    state_next    = state_reg;
    rounds_next   = rounds_reg;
    paused_next   = paused_reg;
    beep_pe_next  = 1'b0;
    beep_fin_next = 1'b0;
    tmr_load      = 1'b0;
    tmr_load_val  = '0;
    if (bus.abort) begin
      state_next  = IDLE;
      rounds_next = '0;
      paused_next = 1'b0;
      tmr_load    = 1'b1;
    end else if (in_idle) begin
      if (cfg_latch) begin
        state_next   = nxt_phase;
        rounds_next  = bus.cfg_rounds;
        tmr_load     = 1'b1;
        tmr_load_val = entry_time;
      end
    end else if (active) begin
      if (bus.pause) paused_next = !paused_reg;
      if (phase_end) begin
        state_next   = nxt_phase;
        tmr_load     = 1'b1;
        tmr_load_val = entry_time;
        if (state_reg == WORK && rounds_reg != '0) rounds_next = rounds_reg - CNT_W'(1);
        if (nxt_phase == FINISH) begin
          rounds_next   = '0;
          paused_next   = 1'b0;
          beep_fin_next = 1'b1;
        end else begin
          beep_pe_next  = 1'b1;
        end
      end
    end else if (bus.start) begin
      state_next  = IDLE;
      paused_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rounds_reg   <= '0;
      paused_reg   <= 1'b0;
      beep_pe_reg  <= 1'b0;
      beep_fin_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rounds_reg   <= rounds_next;
      paused_reg   <= paused_next;
      beep_pe_reg  <= beep_pe_next;
      beep_fin_reg <= beep_fin_next;
    end
  end

  assign bus.state_out      = state_reg;
  assign bus.time_left      = tmr_time;
  assign bus.rounds_left    = rounds_reg;
  assign bus.paused         = paused_reg;
  assign bus.busy           = active;
  assign bus.beep_phase_end = beep_pe_reg;
  assign bus.beep_finish    = beep_fin_reg;
  assign bus.done           = (state_reg == FINISH);

endmodule

// File: tb/tb_interval_sequencer.sv
// Self-checking bench for interval_sequencer: per-cycle vector table plus
// hand-written session, pause and asynchronous-reset sequences.
module tb_interval_sequencer;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  interval_sequencer_if #(.TIME_W(8), .CNT_W(8)) bus ();

  interval_sequencer #(
    .TIME_W(8), .CNT_W(8), .WARMUP_EN(1), .COOLDOWN_EN(1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Input flag encoding: {tick, start, skip, pause, abort}
  localparam logic [4:0] NO = 5'b00000;
  localparam logic [4:0] TK = 5'b10000;
  localparam logic [4:0] ST = 5'b01000;
  localparam logic [4:0] SK = 5'b00100;
  localparam logic [4:0] PZ = 5'b00010;
  localparam logic [4:0] AB = 5'b00001;

  typedef struct {
    logic [4:0]  in;
    logic [7:0]  rounds, work, rest, warm, cool;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [2:0] st;
    logic [7:0] tl;
    logic [7:0] rl;
    int         dur;
  } phase_rec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  phase_rec_t  ph_q[$];
  logic [7:0]  c_rounds, c_work, c_rest, c_warm, c_cool;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] mk(int st, int tl, int rl, int pz, int bpe, int bfin);
    logic busy, done;
    busy = (st >= 1) && (st <= 4);
    done = (st == 5);
    return {8'd0, 3'(st), 8'(tl), 8'(rl), 1'(pz), 1'(bpe), 1'(bfin), busy, done};
  endfunction

  function automatic logic [31:0] snap();
    return {8'd0, bus.state_out, bus.time_left, bus.rounds_left, bus.paused,
            bus.beep_phase_end, bus.beep_finish, bus.busy, bus.done};
  endfunction

  function automatic void cfg(int r, int w, int rs, int wa, int co);
    c_rounds = 8'(r); c_work = 8'(w); c_rest = 8'(rs); c_warm = 8'(wa); c_cool = 8'(co);
  endfunction

  function automatic void add(logic [4:0] in, int st, int tl, int rl, int pz, int bpe, int bfin);
    vec_t v;
    v.in = in; v.rounds = c_rounds; v.work = c_work; v.rest = c_rest;
    v.warm = c_warm; v.cool = c_cool;
    v.exp = mk(st, tl, rl, pz, bpe, bfin);
    vecs.push_back(v);
  endfunction

  function automatic void push_ph(int st, int tl, int rl, int dur);
    phase_rec_t p;
    p.st = 3'(st); p.tl = 8'(tl); p.rl = 8'(rl); p.dur = dur;
    ph_q.push_back(p);
  endfunction

  task automatic drive(logic [4:0] f);
    {bus.tick, bus.start, bus.skip, bus.pause, bus.abort} = f;
  endtask

  task automatic set_cfg(logic [7:0] r, logic [7:0] w, logic [7:0] rs, logic [7:0] wa, logic [7:0] co);
    bus.cfg_rounds = r; bus.cfg_work_s = w; bus.cfg_rest_s = rs;
    bus.cfg_warm_s = wa; bus.cfg_cool_s = co;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    phase_rec_t  pr;
    logic [2:0]  prev_st;
    bit          t, fin;
    int          ticks, cur_dur, nbpe, nbfin, nboth;

    drive(NO);
    set_cfg(8'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", snap(), mk(0, 0, 0, 0, 0, 0));
    reset = 1'b1;
    @(posedge clk); #1;
    check("reset_release_idle", snap(), mk(0, 0, 0, 0, 0, 0));

    // start with zero rounds is ignored
    cfg(0, 3, 2, 0, 0);
    add(ST, 0, 0, 0, 0, 0, 0);
    add(TK, 0, 0, 0, 0, 0, 0);
    // full path with skip, tick+skip into FINISH, start out of FINISH
    cfg(1, 3, 2, 2, 2);
    add(ST, 1, 2, 1, 0, 0, 0);
    add(TK, 1, 1, 1, 0, 0, 0);
    add(TK, 2, 3, 1, 0, 1, 0);
    add(SK, 4, 2, 0, 0, 1, 0);
    add(SK | TK, 5, 0, 0, 0, 0, 1);
    add(NO, 5, 0, 0, 0, 0, 0);
    add(PZ, 5, 0, 0, 0, 0, 0);
    add(ST, 0, 0, 0, 0, 0, 0);
    add(NO, 0, 0, 0, 0, 0, 0);
    // work duration 0 runs as 1 second
    cfg(1, 0, 0, 0, 0);
    add(ST, 2, 1, 1, 0, 0, 0);
    add(TK, 5, 0, 0, 0, 0, 1);
    add(AB, 0, 0, 0, 0, 0, 0);
    // rest and warmup of 0: back-to-back WORK phases
    cfg(3, 3, 0, 0, 0);
    add(ST, 2, 3, 3, 0, 0, 0);
    add(SK, 2, 3, 2, 0, 1, 0);
    add(TK, 2, 2, 2, 0, 0, 0);
    add(TK, 2, 1, 2, 0, 0, 0);
    add(TK, 2, 3, 1, 0, 1, 0);
    add(SK, 5, 0, 0, 0, 0, 1);
    add(TK, 5, 0, 0, 0, 0, 0);
    add(ST, 0, 0, 0, 0, 0, 0);
    // pause holds the countdown; config edits after start are ignored
    cfg(2, 8, 2, 0, 0);
    add(ST, 2, 8, 2, 0, 0, 0);
    cfg(5, 99, 7, 9, 9);
    add(TK, 2, 7, 2, 0, 0, 0);
    add(TK, 2, 6, 2, 0, 0, 0);
    add(TK, 2, 5, 2, 0, 0, 0);
    add(PZ, 2, 5, 2, 1, 0, 0);
    for (int k = 0; k < 10; k++) add(TK, 2, 5, 2, 1, 0, 0);
    add(SK, 2, 5, 2, 1, 0, 0);
    add(PZ, 2, 5, 2, 0, 0, 0);
    add(TK, 2, 4, 2, 0, 0, 0);
    add(TK, 2, 3, 2, 0, 0, 0);
    add(TK | SK, 3, 2, 1, 0, 1, 0);
    add(TK, 3, 1, 1, 0, 0, 0);
    add(TK, 2, 8, 1, 0, 1, 0);
    add(AB | ST, 0, 0, 0, 0, 0, 0);
    add(NO, 0, 0, 0, 0, 0, 0);
    // abort clears pause; pause ignored in IDLE; abort beats start
    cfg(2, 8, 2, 0, 0);
    add(ST, 2, 8, 2, 0, 0, 0);
    add(PZ, 2, 8, 2, 1, 0, 0);
    add(AB, 0, 0, 0, 0, 0, 0);
    add(PZ, 0, 0, 0, 0, 0, 0);
    add(AB | ST, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      set_cfg(vecs[i].rounds, vecs[i].work, vecs[i].rest, vecs[i].warm, vecs[i].cool);
      drive(vecs[i].in);
      exp_q.push_back(vecs[i].exp);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      $display("vec %0d in=%b state=%0d time_left=%0d rounds_left=%0d paused=%0d",
               i, vecs[i].in, bus.state_out, bus.time_left, bus.rounds_left, bus.paused);
      check($sformatf("vec%0d", i), snap(), e);
    end
    drive(NO);

    // Full session, tick every 4 clocks; phases popped from the scoreboard on each change
    set_cfg(8'd2, 8'd3, 8'd2, 8'd2, 8'd2);
    push_ph(1, 2, 2, 2);
    push_ph(2, 3, 2, 3);
    push_ph(3, 2, 1, 2);
    push_ph(2, 3, 1, 3);
    push_ph(4, 2, 0, 2);
    push_ph(5, 0, 0, 0);
    prev_st = 3'd0; fin = 1'b0; ticks = 0; cur_dur = 0;
    nbpe = 0; nbfin = 0; nboth = 0;
    for (int n = 0; n < 300 && !fin; n++) begin
      t = (n > 0) && (n % 4 == 0);
      drive(n == 0 ? ST : (t ? TK : NO));
      @(posedge clk); #1;
      if (t) ticks++;
      if (bus.beep_phase_end) nbpe++;
      if (bus.beep_finish) nbfin++;
      if (bus.beep_phase_end && bus.beep_finish) nboth++;
      if (bus.state_out != prev_st) begin
        if (prev_st != 3'd0) check("t1_phase_ticks", ticks, cur_dur);
        check("t1_phase_expected", 32'(ph_q.size() != 0), 32'd1);
        if (ph_q.size() != 0) begin
          pr = ph_q.pop_front();
          $display("session phase state=%0d time_left=%0d rounds_left=%0d",
                   bus.state_out, bus.time_left, bus.rounds_left);
          check("t1_phase_entry", {13'd0, bus.state_out, bus.time_left, bus.rounds_left},
                {13'd0, pr.st, pr.tl, pr.rl});
          cur_dur = pr.dur;
        end
        ticks = 0;
        prev_st = bus.state_out;
        if (bus.state_out == 3'd5) fin = 1'b1;
      end
    end
    check("t1_reached_finish", 32'(fin), 32'd1);
    check("t1_beep_phase_end_count", nbpe, 4);
    check("t1_beep_finish_count", nbfin, 1);
    check("t1_beeps_overlap", nboth, 0);
    check("t1_scoreboard_drained", ph_q.size(), 0);
    drive(ST);
    @(posedge clk); #1;
    check("t1_finish_to_idle", snap(), mk(0, 0, 0, 0, 0, 0));

    // Asynchronous reset in the middle of REST
    set_cfg(8'd2, 8'd3, 8'd5, 8'd0, 8'd0);
    drive(ST);
    @(posedge clk); #1;
    drive(TK);
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rest", snap(), mk(3, 5, 1, 0, 1, 0));
    drive(NO);
    #2 reset = 1'b0;
    #1;
    check("rst_async_clear", snap(), mk(0, 0, 0, 0, 0, 0));
    #2 reset = 1'b1;
    drive(TK);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      $display("post-reset tick %0d state=%0d time_left=%0d", k, bus.state_out, bus.time_left);
      check($sformatf("rst_tick_idle%0d", k), snap(), mk(0, 0, 0, 0, 0, 0));
    end
    drive(NO);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
